symbol_aligner_10b: RTL

- Serial-to-parallel front end placed directly upstream of the 10b/8b decoder.
- Shifts in one line bit per enabled clock and hunts for the K28.5 comma.
- Locks 10-bit symbol boundaries to the comma and presents aligned 10-bit words plus a valid strobe and lock status to the decoder's data_in.

---
 rtl/symbol_aligner_10b.sv | 127 ++++++++++++
 1 files changed

// File: rtl/symbol_aligner_10b.sv
// Serial-to-parallel K28.5 comma aligner that feeds aligned 10-bit symbols to the 10b/8b decoder.
// Latency: 1 clk from the enabled edge that shifts in bit j to data_out/data_valid.
// Backpressure: none; ser_en=0 freezes all state and outputs, data_valid is forced low.
// Optional build macro SYMBOL_DISP_CHK_EN: out-of-range ones-count symbols also count as lock errors.
module symbol_aligner_10b #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_en,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       is_comma,
  output logic       locked
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [9:0] K28_NEG   = 10'b0011111010;
  localparam logic [9:0] K28_POS   = 10'b1100000101;
  localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);

  state_t     state;
  logic [9:0] sh;
  logic [3:0] ph;
  logic [3:0] lcnt;
  logic [3:0] ecnt;
  logic       comma;
  logic       boundary;
  logic       sym_err;

  assign comma    = (sh == K28_NEG) || (sh == K28_POS);
  assign boundary = (ph == 4'd0);

`ifdef SYMBOL_DISP_CHK_EN
  logic [3:0] ones;

  // Ones count of the symbol currently held in the shift register
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'd0, sh[i]};
    end
  end

  assign sym_err = boundary && !comma && ((ones < 4'd4) || (ones > 4'd6));
`else
  assign sym_err = 1'b0;
`endif

  // Shift/phase tracking, alignment FSM and registered symbol output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      sh         <= 10'd0;
      ph         <= 4'd0;
      lcnt       <= 4'd0;
      ecnt       <= 4'd0;
      data_out   <= 10'd0;
      data_valid <= 1'b0;
      is_comma   <= 1'b0;
      locked     <= 1'b0;
    end else if (!ser_en) begin
      data_valid <= 1'b0;
    end else begin
      sh         <= {sh[8:0], ser_in};
      ph         <= (ph == 4'd9) ? 4'd0 : ph + 4'd1;
      data_valid <= 1'b0;

      // Only symbols framed while already locked reach the decoder
      if ((state == LOCKED) && boundary) begin
        data_out   <= sh;
        is_comma   <= comma;
        data_valid <= 1'b1;
      end

      case (state)
        HUNT: begin
          if (comma) begin
            ph   <= 4'd1;
            lcnt <= 4'd1;
            if (LOCK_CNT == 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
              ecnt   <= 4'd0;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (comma && boundary) begin
            lcnt <= lcnt + 4'd1;
            if ((lcnt + 4'd1) == LOCK_TH) begin
              state  <= LOCKED;
              locked <= 1'b1;
              ecnt   <= 4'd0;
            end
          end else if (comma) begin
            // Comma off the tentative boundary: restart the count at this phase
            ph   <= 4'd1;
            lcnt <= 4'd1;
          end
        end
        LOCKED: begin
          if (comma && boundary) begin
            ecnt <= 4'd0;
          end else if (comma || sym_err) begin
            if ((ecnt + 4'd1) == UNLOCK_TH) begin
              state  <= HUNT;
              locked <= 1'b0;
              lcnt   <= 4'd0;
              ecnt   <= 4'd0;
            end else begin
              ecnt <= ecnt + 4'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
